id_ex_pipe_ctrl: RTL and testbench

Parametrised ID/EX pipeline register with an integrated, multi-cycle load-use hazard controller. It captures a generic decoded payload from the decode stage and presents it to EX, which makes it the successor to the fixed-field ID/EX latch. It inserts LOAD_LATENCY bubbles after a load whose rd is consumed by the following instruction, and implements flush, busywait and hold priorities. It also exports the stall to the IF/ID stage.

---
 rtl/id_ex_pipe_ctrl.sv | 115 +++++++++++
 tb/tb_id_ex_pipe_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_ctrl.sv
// rtl/id_ex_pipe_ctrl.sv - ID/EX pipeline register with multi-cycle load-use hazard control.
// Flush beats busywait beats hold beats the hazard/bubble sequencer.
module id_ex_pipe_ctrl #(
  parameter int PAYLOAD_W    = 160,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  busywait_i,
  input  logic                  hold_i,
  input  logic                  id_valid_i,
  input  logic [PAYLOAD_W-1:0]  id_payload_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  id_is_load_i,
  output logic                  ex_valid_o,
  output logic [PAYLOAD_W-1:0]  ex_payload_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_o,
  output logic                  ex_is_load_o,
  output logic                  stall_o
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ex_valid_q;
  logic [PAYLOAD_W-1:0]    ex_payload_q;
  logic [REG_ADDR_W-1:0]   ex_rd_q;
  logic [REG_ADDR_W-1:0]   ex_rs1_q;
  logic [REG_ADDR_W-1:0]   ex_rs2_q;
  logic                    ex_is_load_q;

  logic rs1_hit;
  logic rs2_hit;
  logic hazard;

  // x0 is excluded through the ex_rd_q != 0 term; unused sources never match.
  assign rs1_hit = id_rs1_used_i && (id_rs1_i == ex_rd_q);
  assign rs2_hit = id_rs2_used_i && (id_rs2_i == ex_rd_q);
  assign hazard  = (state_q == RUN) && id_valid_i && ex_valid_q && ex_is_load_q &&
                   (ex_rd_q != '0) && (rs1_hit || rs2_hit);

  assign stall_o = busywait_i || hold_i || hazard || (state_q == WAIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      ex_valid_q   <= 1'b0;
      ex_payload_q <= '0;
      ex_rd_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_is_load_q <= 1'b0;
    end else if (flush_i) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      ex_valid_q   <= 1'b0;
      ex_payload_q <= '0;
      ex_rd_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_is_load_q <= 1'b0;
    end else if (busywait_i || hold_i) begin
      state_q <= state_q;
    end else if ((state_q == RUN) && hazard) begin
      ex_valid_q   <= 1'b0;
      ex_payload_q <= '0;
      ex_rd_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_is_load_q <= 1'b0;
      // The hazard cycle itself is the first bubble; WAIT supplies the rest.
      if (LOAD_LATENCY > 1) begin
        state_q <= WAIT;
        cnt_q   <= CNT_W'(LOAD_LATENCY - 1);
      end
    end else if (state_q == WAIT) begin
      ex_valid_q   <= 1'b0;
      ex_payload_q <= '0;
      ex_rd_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_is_load_q <= 1'b0;
      cnt_q        <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_q <= RUN;
      end
    end else begin
      ex_valid_q   <= id_valid_i;
      ex_payload_q <= id_valid_i ? id_payload_i : '0;
      ex_rd_q      <= id_valid_i ? id_rd_i : '0;
      ex_rs1_q     <= id_valid_i ? id_rs1_i : '0;
      ex_rs2_q     <= id_valid_i ? id_rs2_i : '0;
      ex_is_load_q <= id_valid_i && id_is_load_i;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_payload_o = ex_payload_q;
  assign ex_rd_o      = ex_rd_q;
  assign ex_rs1_o     = ex_rs1_q;
  assign ex_rs2_o     = ex_rs2_q;
  assign ex_is_load_o = ex_is_load_q;

endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// tb/tb_id_ex_pipe_ctrl.sv - directed bench for id_ex_pipe_ctrl.
// Instance a runs LOAD_LATENCY=1, instance b runs LOAD_LATENCY=3.
module tb_id_ex_pipe_ctrl;
  localparam int PW = 32;

  typedef struct packed {
    logic          flush, busy, hold, valid;
    logic [PW-1:0] pl;
    logic [4:0]    rd, rs1, rs2;
    logic          u1, u2, ld;
  } id_t;

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] pl;
    logic [4:0]    rd, rs1, rs2;
    logic          ld, stall;
  } ex_t;

  logic clk = 1'b0;
  logic rst;
  id_t  ia, ib;
  ex_t  oa, ob;
  int   n_cmp = 0;
  int   n_err = 0;

  logic          a_v, a_ld, a_st, b_v, b_ld, b_st;
  logic [PW-1:0] a_pl, b_pl;
  logic [4:0]    a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;

  always #5 clk = ~clk;

  assign oa = {a_v, a_pl, a_rd, a_rs1, a_rs2, a_ld, a_st};
  assign ob = {b_v, b_pl, b_rd, b_rs1, b_rs2, b_ld, b_st};

  id_ex_pipe_ctrl #(.PAYLOAD_W(PW), .REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(3)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(ia.flush), .busywait_i(ia.busy), .hold_i(ia.hold),
    .id_valid_i(ia.valid), .id_payload_i(ia.pl), .id_rd_i(ia.rd), .id_rs1_i(ia.rs1),
    .id_rs2_i(ia.rs2), .id_rs1_used_i(ia.u1), .id_rs2_used_i(ia.u2), .id_is_load_i(ia.ld),
    .ex_valid_o(a_v), .ex_payload_o(a_pl), .ex_rd_o(a_rd), .ex_rs1_o(a_rs1),
    .ex_rs2_o(a_rs2), .ex_is_load_o(a_ld), .stall_o(a_st)
  );

  id_ex_pipe_ctrl #(.PAYLOAD_W(PW), .REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(3)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(ib.flush), .busywait_i(ib.busy), .hold_i(ib.hold),
    .id_valid_i(ib.valid), .id_payload_i(ib.pl), .id_rd_i(ib.rd), .id_rs1_i(ib.rs1),
    .id_rs2_i(ib.rs2), .id_rs1_used_i(ib.u1), .id_rs2_used_i(ib.u2), .id_is_load_i(ib.ld),
    .ex_valid_o(b_v), .ex_payload_o(b_pl), .ex_rd_o(b_rd), .ex_rs1_o(b_rs1),
    .ex_rs2_o(b_rs2), .ex_is_load_o(b_ld), .stall_o(b_st)
  );

  function automatic id_t mk(input logic v, input logic [PW-1:0] pl, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic ld);
    id_t t;
    t = '0;
    t.valid = v; t.pl = pl; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.u1 = u1; t.u2 = u2; t.ld = ld;
    return t;
  endfunction

  function automatic ex_t get(input bit sel);
    return sel ? ob : oa;
  endfunction

  task automatic drive(input bit sel, input id_t v);
    if (sel) ib = v; else ia = v;
  endtask

  task automatic set_busy(input bit sel, input logic b);
    if (sel) ib.busy = b; else ia.busy = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_in();
    logic [63:0] r;
    r = {$urandom, $urandom};
    ia = id_t'(r[$bits(id_t)-1:0]);
    ia.busy = 1'b0; ia.hold = 1'b0;
    r = {$urandom, $urandom};
    ib = id_t'(r[$bits(id_t)-1:0]);
    ib.busy = 1'b0; ib.hold = 1'b0;
  endtask

  // Puts lw x5 into EX of the chosen instance, then presents dep in ID.
  task automatic lw_then(input bit sel, input id_t dep);
    drive(sel, mk(1'b1, 32'h0000_1111, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1));
    tick();
    drive(sel, dep);
  endtask

  // Clocks until the dependent instruction (rd=exp_rd) is seen in EX, counting
  // stall cycles and bubble edges that were not frozen by busywait.
  task automatic hazard_run(input string tag, input bit sel, input int bz0, input int bz1,
                            input int exp_stall, input int exp_bub,
                            input logic [4:0] exp_rd, input logic [PW-1:0] exp_pl);
    int   stalls = 0;
    int   bubs = 0;
    bit   found = 0;
    bit   bz;
    ex_t  o;
    for (int c = 0; c < 12 && !found; c++) begin
      bz = (c == bz0) || (c == bz1);
      set_busy(sel, bz);
      #1;
      o = get(sel);
      if (o.stall) stalls++;
      tick();
      o = get(sel);
      if (o.valid && o.rd == exp_rd) found = 1;
      else if (!bz) bubs++;
    end
    set_busy(sel, 1'b0);
    o = get(sel);
    chk({tag, "_found"}, 64'(found), 64'd1);
    chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
    chk({tag, "_bubbles"}, 64'(bubs), 64'(exp_bub));
    chk({tag, "_payload"}, 64'(o.pl), 64'(exp_pl));
  endtask

  id_t add_dep;

  initial begin
    rst = 1'b1;
    rand_in();
    tick();
    chk("rst_stall_a", 64'(oa.stall), 64'd0);
    chk("rst_stall_b", 64'(ob.stall), 64'd0);
    rand_in();
    tick();
    chk("rst_ex_a", 64'(oa[$bits(ex_t)-1:1]), 64'd0);
    chk("rst_ex_b", 64'(ob[$bits(ex_t)-1:1]), 64'd0);
    chk("rst_stall2_a", 64'(oa.stall), 64'd0);

    rst = 1'b0;
    ia = mk(1'b1, 32'hCAFE_0001, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    ib = ia;
    tick();
    chk("first_valid", 64'(oa.valid), 64'd1);
    chk("first_rd", 64'(oa.rd), 64'd9);
    chk("first_pl", 64'(ob.pl), 64'hCAFE_0001);

    add_dep = mk(1'b1, 32'h2222_0006, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);
    lw_then(0, add_dep);
    hazard_run("ll1", 0, -1, -1, 1, 1, 5'd6, 32'h2222_0006);
    lw_then(1, add_dep);
    hazard_run("ll3", 1, -1, -1, 3, 3, 5'd6, 32'h2222_0006);
    lw_then(1, add_dep);
    hazard_run("ll3_busy", 1, 2, 3, 5, 3, 5'd6, 32'h2222_0006);
    lw_then(0, mk(1'b1, 32'h3333_0006, 5'd6, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0));
    hazard_run("ll1_rs2", 0, -1, -1, 1, 1, 5'd6, 32'h3333_0006);

    drive(1, mk(1'b1, 32'h0000_0A00, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1));
    tick();
    drive(1, mk(1'b1, 32'h0000_0A01, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0));
    #1 chk("x0_stall", 64'(ob.stall), 64'd0);
    tick();
    chk("x0_rd", 64'(ob.rd), 64'd1);
    lw_then(1, mk(1'b1, 32'h0000_0B05, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0));
    #1 chk("unused_stall", 64'(ob.stall), 64'd0);
    tick();
    chk("unused_ex", 64'({ob.valid, ob.rd, ob.ld}), 64'({1'b1, 5'd5, 1'b0}));
    lw_then(1, mk(1'b1, 32'h0000_0C06, 5'd6, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0));
    #1 chk("indep_stall", 64'(ob.stall), 64'd0);
    tick();
    chk("indep_ex", 64'({ob.valid, ob.rd}), 64'({1'b1, 5'd6}));

    lw_then(1, add_dep);
    tick();
    #1 chk("wait1_stall", 64'(ob.stall), 64'd1);
    tick();
    ib.flush = 1'b1;
    #1 chk("flush_wait_stall", 64'(ob.stall), 64'd1);
    tick();
    ib = mk(1'b1, 32'h5555_0009, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0);
    chk("flush_bubble", 64'(ob.valid), 64'd0);
    #1 chk("flush_after_stall", 64'(ob.stall), 64'd0);
    tick();
    chk("flush_next", 64'({ob.valid, ob.rd, ob.pl}), 64'({1'b1, 5'd9, 32'h5555_0009}));

    add_dep.flush = 1'b1;
    lw_then(0, add_dep);
    #1 chk("flush_haz_stall", 64'(oa.stall), 64'd1);
    tick();
    chk("flush_haz_ex", 64'(oa.valid), 64'd0);
    ia = mk(1'b1, 32'h0000_0707, 5'd7, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
    tick();
    ia.flush = 1'b1;
    ia.busy = 1'b1;
    tick();
    chk("flush_over_busy", 64'(oa.valid), 64'd0);

    ia = mk(1'b1, 32'hA5A5_A5A5, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    ia = mk(1'b1, 32'h4444_4444, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    ia.hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("hold_stall", 64'(oa.stall), 64'd1);
      tick();
      chk("hold_ex", 64'({oa.valid, oa.rd, oa.pl}), 64'({1'b1, 5'd3, 32'hA5A5_A5A5}));
    end
    ia.hold = 1'b0;
    tick();
    chk("hold_release", 64'({oa.valid, oa.rd, oa.pl}), 64'({1'b1, 5'd4, 32'h4444_4444}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
